// File: rtl/vram_wb_pkg.sv
// Shared types and constants for the VRAM write buffer: queued entry layout,
// drain FSM states and upstream stall slack.
package vram_wb_pkg;

  localparam int STALL_SLACK = 2;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic        page;
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
  } vram_wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a read-ahead head: o_dout shows the oldest entry
// whenever o_empty is low. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/vram_write_buffer.sv
// Buffers rasterizer VRAM writes, drains them over req/ack to the framebuffer
// controller, and flips front/back pages on vsync once earlier writes retire.
module vram_write_buffer
  import vram_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        vram_sel_i,
  input  logic        vram_wr_i,
  input  logic [3:0]  vram_mask_i,
  input  logic [15:0] vram_addr_i,
  input  logic [15:0] vram_data_in_i,
  input  logic        swap_i,
  input  logic        vsync_i,
  output logic        stall_o,
  output logic        overflow_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  output logic [16:0] mem_addr_o,
  output logic [3:0]  mem_mask_o,
  output logic [15:0] mem_data_o,
  output logic        front_page_o,
  output logic        swap_pending_o,
  output logic        busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - STALL_SLACK);

  drain_state_t   r_state;
  drain_state_t   w_state_nxt;
  vram_wb_entry_t w_din;
  vram_wb_entry_t w_head;
  logic [CW-1:0]  w_count;
  logic           w_full;
  logic           w_empty;
  logic           w_wr;
  logic           w_pop;
  logic           w_req_nxt;
  logic           w_swap_go;

  logic           r_req;
  logic [16:0]    r_addr;
  logic [3:0]     r_mask;
  logic [15:0]    r_data;
  logic           r_front;
  logic           r_pending;
  logic           r_overflow;
  logic           r_vsync_q;

  assign w_wr  = vram_sel_i & vram_wr_i;
  assign w_din = '{page: ~r_front, mask: vram_mask_i, addr: vram_addr_i, data: vram_data_in_i};

  sync_fifo #(
    .WIDTH ($bits(vram_wb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset_i),
    .i_push  (w_wr),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The swap may only fire once every earlier write has been accepted by memory.
  assign w_swap_go = r_pending & w_empty & (r_state == IDLE) & vsync_i & ~r_vsync_q;

  // Handshake: mem_* are held stable while mem_req_o is high; a transfer
  // completes at a clock edge where mem_req_o and mem_ack_i are both high.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_req_nxt   = r_req;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      r_front    <= 1'b0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_vsync_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_vsync_q <= vsync_i;
      if (w_pop) begin
        r_addr <= {w_head.page, w_head.addr};
        r_mask <= w_head.mask;
        r_data <= w_head.data;
      end
      if (w_wr && w_full) r_overflow <= 1'b1;
      if (w_swap_go) begin
        r_front   <= ~r_front;
        r_pending <= 1'b0;
      end else if (swap_i) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign mem_req_o      = r_req;
  assign mem_addr_o     = r_addr;
  assign mem_mask_o     = r_mask;
  assign mem_data_o     = r_data;
  assign front_page_o   = r_front;
  assign swap_pending_o = r_pending;
  assign overflow_o     = r_overflow;
  assign stall_o        = (w_count >= STALL_LEVEL) | r_pending;
  assign busy_o         = ~w_empty | r_req | r_pending;

endmodule

// File: tb/tb_vram_write_buffer.sv
// Randomised and directed bench for vram_write_buffer against a queue-based
// model of the write path, page swap and sticky overflow.
module tb_vram_write_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        vram_sel_i, vram_wr_i;
  logic [3:0]  vram_mask_i;
  logic [15:0] vram_addr_i, vram_data_in_i;
  logic        swap_i, vsync_i;
  logic        stall_o, overflow_o, mem_req_o, mem_ack_i;
  logic [16:0] mem_addr_o;
  logic [3:0]  mem_mask_o;
  logic [15:0] mem_data_o;
  logic        front_page_o, swap_pending_o, busy_o;

  // clock / reset
  always #5 clk = ~clk;

  vram_write_buffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .vram_sel_i     (vram_sel_i),
    .vram_wr_i      (vram_wr_i),
    .vram_mask_i    (vram_mask_i),
    .vram_addr_i    (vram_addr_i),
    .vram_data_in_i (vram_data_in_i),
    .swap_i         (swap_i),
    .vsync_i        (vsync_i),
    .stall_o        (stall_o),
    .overflow_o     (overflow_o),
    .mem_req_o      (mem_req_o),
    .mem_ack_i      (mem_ack_i),
    .mem_addr_o     (mem_addr_o),
    .mem_mask_o     (mem_mask_o),
    .mem_data_o     (mem_data_o),
    .front_page_o   (front_page_o),
    .swap_pending_o (swap_pending_o),
    .busy_o         (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: entries are {page, mask, addr, data}
  logic [36:0] m_fifo[$];
  logic [36:0] exp_q[$];
  logic [36:0] m_out;
  logic        m_out_v, m_front, m_pending, m_overflow, m_vs_prev;
  logic [36:0] last_obs;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_out      = '0;
    m_out_v    = 1'b0;
    m_front    = 1'b0;
    m_pending  = 1'b0;
    m_overflow = 1'b0;
    m_vs_prev  = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs present at that edge.
  task automatic model_edge(input logic wr, input logic [3:0] mask, input logic [15:0] addr,
                            input logic [15:0] data, input logic swp, input logic vs,
                            input logic ack);
    logic full, go;
    logic [36:0] exp_e;
    full = (m_fifo.size() == DEPTH);
    go   = m_pending && (m_fifo.size() == 0) && !m_out_v && vs && !m_vs_prev;
    if (m_out_v && ack && exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      check_eq("retire_order", last_obs, exp_e);
    end
    if ((!m_out_v || ack) && m_fifo.size() > 0) begin
      m_out   = m_fifo.pop_front();
      m_out_v = 1'b1;
    end else if (ack) begin
      m_out_v = 1'b0;
    end
    if (wr) begin
      if (!full) begin
        m_fifo.push_back({~m_front, mask, addr, data});
        exp_q.push_back({~m_front, mask, addr, data});
      end else begin
        m_overflow = 1'b1;
      end
    end
    if (go) begin
      m_front   = ~m_front;
      m_pending = 1'b0;
    end else if (swp) begin
      m_pending = 1'b1;
    end
    m_vs_prev = vs;
  endtask

  task automatic compare_outputs();
    last_obs = {mem_addr_o[16], mem_mask_o, mem_addr_o[15:0], mem_data_o};
    check_eq("mem_req", mem_req_o, m_out_v);
    check_eq("stall", stall_o, (m_fifo.size() >= DEPTH - 2) || m_pending);
    check_eq("busy", busy_o, (m_fifo.size() > 0) || m_out_v || m_pending);
    check_eq("front_page", front_page_o, m_front);
    check_eq("swap_pending", swap_pending_o, m_pending);
    check_eq("overflow", overflow_o, m_overflow);
    if (m_out_v) check_eq("mem_entry", last_obs, m_out);
  endtask

  // driver: called at a negedge, returns at the following negedge
  task automatic step(input logic sel, input logic wr, input logic [3:0] mask,
                      input logic [15:0] addr, input logic [15:0] data,
                      input logic swp, input logic vs, input logic ack);
    vram_sel_i = sel; vram_wr_i = wr; vram_mask_i = mask; vram_addr_i = addr;
    vram_data_in_i = data; swap_i = swp; vsync_i = vs; mem_ack_i = ack;
    @(posedge clk);
    model_edge(sel & wr, mask, addr, data, swp, vs, ack);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, ack);
  endtask

  task automatic do_reset();
    #2 reset_i = 1'b1;
    #1 check_eq("reset_async_req", mem_req_o, 1'b0);
    vram_sel_i = 1'b0; vram_wr_i = 1'b0; swap_i = 1'b0; vsync_i = 1'b0; mem_ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    compare_outputs();
  endtask

  logic vs_r;

  initial begin
    reset_i = 1'b1;
    vram_sel_i = 1'b0; vram_wr_i = 1'b0; vram_mask_i = '0; vram_addr_i = '0;
    vram_data_in_i = '0; swap_i = 1'b0; vsync_i = 1'b0; mem_ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_addr", mem_addr_o, 17'h0);
    check_eq("rst_mask", mem_mask_o, 4'h0);
    check_eq("rst_data", mem_data_o, 16'h0);
    compare_outputs();
    reset_i = 1'b0;
    @(negedge clk);
    compare_outputs();

    // single write, ack held high
    step(1'b1, 1'b1, 4'hF, 16'h0123, 16'hABCD, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_eq("single_addr", mem_addr_o, 17'h10123);
    check_eq("single_data", mem_data_o, 16'hABCD);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_eq("single_busy_fall", busy_o, 1'b0);

    // burst of 20 with ack low, then drain
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 4'($urandom), 16'(i), 16'($urandom), 1'b0, 1'b0, 1'b0);
    check_eq("burst_overflow", overflow_o, 1'b1);
    check_eq("burst_stall", stall_o, 1'b1);
    idle(20, 1'b1);

    // ack withheld mid-burst
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0,
           (i < 4 || i > 8) ? 1'b1 : 1'b0);
    idle(16, 1'b1);

    // swap: first vsync edge arrives before drain, second one performs it
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'hF, 16'(16'h0200 + i), 16'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    check_eq("swap_early_edge", front_page_o, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(37, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    check_eq("swap_front", front_page_o, 1'b1);
    step(1'b1, 1'b1, 4'h3, 16'h0777, 16'h5A5A, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_eq("post_swap_page", mem_addr_o, 17'h00777);
    idle(2, 1'b1);

    // write and swap in the same cycle
    step(1'b1, 1'b1, 4'h5, 16'h0ABC, 16'h1234, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("same_cycle_page", mem_addr_o, 17'h00ABC);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    check_eq("same_cycle_hold", front_page_o, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    check_eq("same_cycle_swap", front_page_o, 1'b0);
    idle(1, 1'b1);

    // reset mid-burst
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b1, 4'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // random traffic
    vs_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) vs_r = ~vs_r;
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           4'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           vs_r,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    idle(DEPTH + 4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
